pipe_stall_ctrl: RTL
====================

// Module: pipe_stall_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline registers (pc, if_id, id_ex, ex_mem, mem_wb).
//  Merges stall requests from ID (load-use) and EX (multi-cycle ops) into stall[5:0].
//  Times fixed-length EX stalls with an internal counter and issues one-cycle flush pulses with a redirect PC.
//  Counts stalled cycles for performance monitoring.
// PARAMETERS
//  LEN_W      6    width of mc_len (multi-cycle stall length)
//  PERF_W     32   width of stall_cnt performance counter
//  WDT_LIMIT  256  consecutive stalled cycles before watchdog release (STALL_WDT_EN only)
// PORTS
//  clk           in   1       system clock, rising edge
//  rst           in   1       asynchronous, active-low reset
//  stallreq_id   in   1       level; ID requests stall (load-use hazard)
//  stallreq_ex   in   1       level; EX requests stall (unit busy)
//  mc_start      in   1       pulse; EX starts fixed-length op lasting mc_len cycles
//  mc_len        in   LEN_W   stall length for mc_start; 0 = no stall
//  flush_req     in   1       pulse; redirect pipeline (exception/eret)
//  flush_pc      in   32      redirect target, sampled with flush_req
//  stall         out  6       [0]pc [1]if_id [2]id_ex [3]ex_mem [4]mem_wb [5]wb; 1 = hold
//  flush         out  1       registered one-cycle flush of all pipeline registers
//  new_pc        out  32      redirect PC, valid while flush=1
//  stall_cnt     out  PERF_W  cycles with stall[0]=1; saturates at all-ones
//  wdt_err       out  1       sticky watchdog flag (0 when STALL_WDT_EN undefined)
// BEHAVIOUR
//  Reset (rst=0, immediate): state=RUN, cnt=0, stall=6'b000000, flush=0, new_pc=0, stall_cnt=0, wdt_err=0.
//  States: RUN, EX_WAIT, FLUSH. Priority flush_req > EX (stallreq_ex/mc/EX_WAIT) > stallreq_id.
//  stall is combinational from state and requests, same-cycle: EX stall = 6'b001111, ID stall = 6'b000111, else 0.
//  RUN: mc_start & mc_len!=0 -> stall=001111 this cycle; mc_len==1 stay RUN, else cnt<=mc_len-1, ->EX_WAIT.
//   Total EX stall for mc_start = exactly mc_len cycles, counting start cycle. mc_len==0: mc_start ignored.
//  EX_WAIT: stall=001111 regardless of ID request; cnt<=cnt-1; cnt==1 -> RUN. mc_start ignored here.
//   stallreq_ex in EX_WAIT has no extra effect; after return to RUN it stalls normally if still high.
//  flush_req in any state (flush_req=1 at edge): next state FLUSH, new_pc<=flush_pc, cnt<=0 (EX_WAIT aborted).
//  FLUSH (1 cycle): flush=1, stall=0, all stall requests and mc_start ignored; flush_req again -> stay FLUSH,
//   recapture new_pc; else -> RUN, flush<=0. new_pc holds last value after flush drops.
//  flush latency: 1 cycle from flush_req. stall latency: 0 cycles.
//  stall_cnt: +1 each cycle stall[0]=1, saturating at {PERF_W{1'b1}}; never wraps.
// CONFIGURATION
//  STALL_WDT_EN defined: counter of consecutive cycles with stall[0]=1; on reaching WDT_LIMIT, stall forced
//   to 0 for that one cycle, wdt_err<=1 (sticky until reset), EX_WAIT aborted ->RUN, counter cleared.
//   Counter clears on any cycle with stall[0]=0 or FLUSH.
//  STALL_WDT_EN undefined: no watchdog logic; wdt_err tied 0; stalls held indefinitely.
// TESTING
//  1. stallreq_id=1 one cycle in RUN -> stall=6'b000111 that cycle, then 0; stall_cnt 0->1.
//  2. mc_start, mc_len=4 -> stall=6'b001111 exactly 4 cycles from start cycle; mc_start(len=9) at cycle 2 ignored.
//  3. mc_len=4 then flush_req, flush_pc=32'h0000_0020 in cycle 2 -> next cycle flush=1, new_pc=0x20, stall=0; then RUN, stall=0.
//  4. rst low mid EX_WAIT with stall_cnt=7 -> stall=0, flush=0, new_pc=0, stall_cnt=0 immediately, no clock.
//  5. stallreq_id=1 & stallreq_ex=1 same cycle -> stall=6'b001111; flush_req also set -> next cycle flush=1, stall=0.
//  6. STALL_WDT_EN, stallreq_ex held 300 cycles -> stall=0 at stalled cycle 256, wdt_err=1 sticky; undefined: 300 stalled cycles, wdt_err=0.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges ID/EX stall requests, times fixed-length EX stalls,
// issues flush pulses with a redirect PC and counts stalled cycles. Optional watchdog: `define STALL_WDT_EN.
module pipe_stall_ctrl #(
   parameter int unsigned LEN_W     = 6,
   parameter int unsigned PERF_W    = 32,
   parameter int unsigned WDT_LIMIT = 256
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              stallreq_id_i,
   input  logic              stallreq_ex_i,
   input  logic              mc_start_i,
   input  logic [LEN_W-1:0]  mc_len_i,
   input  logic              flush_req_i,
   input  logic [31:0]       flush_pc_i,
   output logic [5:0]        stall_o,
   output logic              flush_o,
   output logic [31:0]       new_pc_o,
   output logic [PERF_W-1:0] stall_cnt_o,
   output logic              wdt_err_o
);

   localparam int unsigned STALL_W = 6;
   localparam logic [STALL_W-1:0] STALL_EX = 6'b001111;
   localparam logic [STALL_W-1:0] STALL_ID = 6'b000111;

   typedef enum logic [1:0] {RUN, EX_WAIT, FLUSH} state_e;

   state_e             state_q, state_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic               flush_q, flush_d;
   logic [31:0]        new_pc_q, new_pc_d;
   logic [PERF_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic               mc_go;
   logic               ex_stall;
   logic [STALL_W-1:0] stall_raw;
   logic               wdt_fire;

   assign mc_go    = (state_q == RUN) && mc_start_i && (mc_len_i != '0);
   assign ex_stall = (state_q == EX_WAIT) || stallreq_ex_i || mc_go;

   // Same-cycle stall vector; FLUSH overrides every request
   always_comb begin
      stall_raw = '0;
      if (state_q != FLUSH) begin
         if (ex_stall) begin
            stall_raw = STALL_EX;
         end else if (stallreq_id_i) begin
            stall_raw = STALL_ID;
         end
      end
   end

   assign stall_o = wdt_fire ? '0 : stall_raw;

`ifdef STALL_WDT_EN
   localparam int unsigned WDT_W = $clog2(WDT_LIMIT + 1);

   logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
   logic             wdt_err_q, wdt_err_d;

   assign wdt_fire = stall_raw[0] && (wdt_cnt_q == WDT_W'(WDT_LIMIT - 1));

   always_comb begin
      wdt_cnt_d = wdt_cnt_q;
      wdt_err_d = wdt_err_q | wdt_fire;
      if (!stall_o[0] || (state_q == FLUSH)) begin
         wdt_cnt_d = '0;
      end else begin
         wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wdt_cnt_q <= '0;
         wdt_err_q <= 1'b0;
      end else begin
         wdt_cnt_q <= wdt_cnt_d;
         wdt_err_q <= wdt_err_d;
      end
   end

   assign wdt_err_o = wdt_err_q;
`else
   // WDT_LIMIT only matters when the watchdog is built in
   logic unused_wdt_limit;
   assign unused_wdt_limit = (WDT_LIMIT == 0);
   assign wdt_fire         = 1'b0;
   assign wdt_err_o        = 1'b0;
`endif

   // Next state: flush beats watchdog release beats normal sequencing
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      flush_d  = 1'b0;
      new_pc_d = new_pc_q;
      if (flush_req_i) begin
         state_d  = FLUSH;
         flush_d  = 1'b1;
         new_pc_d = flush_pc_i;
         cnt_d    = '0;
      end else if (wdt_fire) begin
         state_d = RUN;
         cnt_d   = '0;
      end else begin
         case (state_q)
            RUN: begin
               if (mc_go && (mc_len_i != LEN_W'(1))) begin
                  cnt_d   = mc_len_i - LEN_W'(1);
                  state_d = EX_WAIT;
               end
            end
            EX_WAIT: begin
               cnt_d = cnt_q - LEN_W'(1);
               if (cnt_q == LEN_W'(1)) begin
                  state_d = RUN;
               end
            end
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
         endcase
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_o[0] && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + PERF_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= RUN;
         cnt_q       <= '0;
         flush_q     <= 1'b0;
         new_pc_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         flush_q     <= flush_d;
         new_pc_q    <= new_pc_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign flush_o     = flush_q;
   assign new_pc_o    = new_pc_q;
   assign stall_cnt_o = stall_cnt_q;

endmodule
